hilo_muldiv_sequencer: RTL and testbench

//   Multi-cycle iterative multiply/divide engine that owns the HI/LO writeback path for MULT, MULTU, DIV, DIVU.

---
 rtl/hilo_muldiv_sequencer.sv | 172 +++++++++++++++++
 tb/tb_hilo_muldiv_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO write path.
// One result bit per cycle, then a sign fix-up cycle and a single HI/LO write pulse.
module hilo_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_we;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi_out;
    logic [WIDTH-1:0]   r_lo_out;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;

    // Operand decode at accept time; signed ops work on magnitudes.
    logic               w_is_signed;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic               w_div_zero_in;

    assign w_is_signed   = ~op[0];
    assign w_rs_neg      = w_is_signed & rs_val[WIDTH-1];
    assign w_rt_neg      = w_is_signed & rt_val[WIDTH-1];
    assign w_rs_mag      = w_rs_neg ? (~rs_val + WIDTH'(1)) : rs_val;
    assign w_rt_mag      = w_rt_neg ? (~rt_val + WIDTH'(1)) : rt_val;
    assign w_div_zero_in = op[1] & (rt_val == '0);

    // Multiply step: r_acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                        (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide step: r_acc = {partial remainder, dividend/quotient bits}.
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ok    = ~w_div_diff[WIDTH];
    assign w_div_next  = w_div_ok ? {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                                  : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    // Sign fix-up of the finished magnitude result.
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_prod_fix = r_neg_res ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
    assign w_quot_fix = r_neg_res ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + WIDTH'(1))
                                  : r_acc[2*WIDTH-1:WIDTH];
    assign w_fix_hi   = r_is_div ? w_rem_fix  : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_fix_lo   = r_is_div ? w_quot_fix : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_we       <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi_out   <= '0;
            r_lo_out   <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_count    <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_div_zero <= w_div_zero_in;
                        r_is_div   <= op[1];
                        r_neg_res  <= w_rs_neg ^ w_rt_neg;
                        r_neg_rem  <= w_rs_neg;
                        r_opb      <= op[1] ? w_rt_mag : w_rs_mag;
                        r_acc      <= {{WIDTH{1'b0}}, (op[1] ? w_rs_mag : w_rt_mag)};
                        r_count    <= CW'(WIDTH);
                        r_busy     <= 1'b1;
                        if (w_div_zero_in) begin
                            // Divide by zero skips iteration and writes immediately.
                            r_state  <= S_WB;
                            r_we     <= 1'b1;
                            r_hi_out <= rs_val;
                            r_lo_out <= '1;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc   <= r_is_div ? w_div_next : w_mul_next;
                        r_count <= r_count - CW'(1);
                        if (r_count == CW'(1)) begin
                            r_state <= S_FIXUP;
                        end
                    end
                end
                S_FIXUP: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state  <= S_WB;
                        r_we     <= 1'b1;
                        r_hi_out <= w_fix_hi;
                        r_lo_out <= w_fix_lo;
                    end
                end
                S_WB: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign hi_we    = r_we;
    assign lo_we    = r_we;
    assign hi_out   = r_hi_out;
    assign lo_out   = r_lo_out;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Randomized + directed bench for hilo_muldiv_sequencer against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         flush;
    logic         busy;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         div_zero;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dz = 1'b0;

    hilo_muldiv_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .busy     (busy),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Architectural result of one op, straight from integer arithmetic.
    function automatic void ref_model(input logic [1:0] f_op, input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        if (f_op[1] && b == '0) begin
            hi = a;
            lo = '1;
        end else begin
            case (f_op)
                2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
                2'b01: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
                2'b10: begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
                default: begin lo = a / b; hi = a % b; end
            endcase
        end
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle afterwards.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int flush_at, input int reset_at, input bit glitch);
        logic [W-1:0] new_hi, new_lo;
        int           len;
        bit           aborted;
        ref_model(o, a, b, new_hi, new_lo);
        len     = (o[1] && b == '0) ? 1 : W + 2;
        aborted = 0;
        start   = 1'b1;
        op      = o;
        rs_val  = a;
        rt_val  = b;
        @(negedge clk);
        exp_dz = o[1] && (b == '0);
        start  = glitch;
        if (glitch) begin
            op     = 2'($urandom);
            rs_val = $urandom;
            rt_val = $urandom;
        end
        for (int c = 1; c <= len; c++) begin
            if (c == len) start = 1'b0;
            check_val("busy", busy, 1'b1);
            check_val("hi_we", hi_we, (c == len));
            check_val("lo_we", lo_we, (c == len));
            if (c < len) begin
                check_val("hi_hold", hi_out, exp_hi);
                check_val("lo_hold", lo_out, exp_lo);
            end else begin
                check_val("hi_out", hi_out, new_hi);
                check_val("lo_out", lo_out, new_lo);
                check_val("div_zero", div_zero, exp_dz);
            end
            if (c == flush_at) flush = 1'b1;
            if (c == reset_at) reset = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            reset = 1'b0;
            if (c == reset_at || (c == flush_at && c < len)) begin
                aborted = 1;
                break;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            exp_hi = new_hi;
            exp_lo = new_lo;
        end else if (reset_at != 0) begin
            exp_hi = '0;
            exp_lo = '0;
            exp_dz = 1'b0;
        end
        check_val("idle_busy", busy, 1'b0);
        check_val("idle_we", hi_we | lo_we, 1'b0);
        check_val("idle_hi", hi_out, exp_hi);
        check_val("idle_lo", lo_out, exp_lo);
        check_val("idle_dz", div_zero, exp_dz);
        $display("txn op=%0d rs=0x%08h rt=0x%08h flush_at=%0d reset_at=%0d glitch=%0d -> hi=0x%08h lo=0x%08h dz=%0d",
                 o, a, b, flush_at, reset_at, glitch, hi_out, lo_out, div_zero);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_a, r_b;
        int           sel;
        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        op     = 2'b00;
        rs_val = '0;
        rt_val = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_we", hi_we | lo_we, 1'b0);
        check_val("rst_hi", hi_out, '0);
        check_val("rst_lo", lo_out, '0);
        check_val("rst_dz", div_zero, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        run_op(2'b01, 32'hFFFF_FFFF, 32'h2, 0, 0, 0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'h5, 0, 0, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h2, 0, 0, 0);
        run_op(2'b11, 32'h7, 32'h2, 0, 0, 0);
        run_op(2'b11, 32'h1234, 32'h0, 0, 0, 0);
        run_op(2'b00, 32'h3, 32'h4, 0, 0, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(2'b10, 32'h8000_0000, 32'h0, 0, 0, 0);
        run_op(2'b00, 32'h0001_2345, 32'h0000_6789, 10, 0, 0);
        run_op(2'b10, 32'hDEAD_BEEF, 32'h0000_0123, 0, 20, 0);
        run_op(2'b01, 32'hCAFE_F00D, 32'h1357_9BDF, 0, 0, 1);
        run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, W + 1, 0, 0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, W + 2, 0, 0);

        // start together with flush in IDLE must not launch an op
        start  = 1'b1;
        flush  = 1'b1;
        op     = 2'b11;
        rs_val = 32'h55;
        rt_val = 32'h0;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check_val("sf_busy", busy, 1'b0);
        check_val("sf_we", hi_we | lo_we, 1'b0);
        check_val("sf_dz", div_zero, exp_dz);
        @(negedge clk);
        check_val("sf_busy2", busy, 1'b0);
        check_val("sf_hi", hi_out, exp_hi);

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            sel  = $urandom_range(0, 7);
            r_a  = $urandom;
            case (sel)
                0: r_b = '0;
                1: r_b = 32'($urandom_range(1, 15));
                2: r_b = 32'hFFFF_FFFF;
                3: r_a = 32'h8000_0000;
                default: r_b = $urandom;
            endcase
            if (sel == 3) r_b = $urandom;
            run_op(r_op, r_a, r_b, 0, 0, bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
